// File: rtl/cart_rom_fetch_if.sv
// Buses around cart_rom_fetch: the mapper-side ROM strobe bus and the SDRAM word-request bus.
interface cart_rom_bus_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce_n;
  logic              rom_oe_n;
  logic              rom_word;
  logic              flush;
  logic [15:0]       rom_q;
  logic              rom_busy;

  modport master (output rom_addr, rom_ce_n, rom_oe_n, rom_word, flush,
                  input  rom_q, rom_busy);
  modport slave  (input  rom_addr, rom_ce_n, rom_oe_n, rom_word, flush,
                  output rom_q, rom_busy);
endinterface

interface cart_mem_if #(
  parameter int unsigned ADDR_W = 24
);
  localparam int unsigned TAG_W = ADDR_W - 1;

  logic             mem_req;
  logic [TAG_W-1:0] mem_addr;
  logic             mem_ack;
  logic [15:0]      mem_q;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_q);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_q);
endinterface

// File: rtl/cart_rom_fetch.sv
// ROM fetch front-end: two-entry word buffer (current + sequential prefetch)
// turning the mapper's ROM strobe bus into req/ack word reads from SDRAM.
module cart_rom_fetch #(
  parameter bit          PREFETCH = 1'b1,
  parameter int unsigned ADDR_W   = 24
) (
  input  logic          mclk,
  input  logic          rst_n,
  cart_rom_bus_if.slave rom,
  cart_mem_if.master    mem
);

  localparam int unsigned TAG_W = ADDR_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_DEMAND, S_PREFETCH} state_e;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [15:0]      data;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           cur_q, cur_d;
  entry_t           nxt_q, nxt_d;
  logic             req_q, req_d;
  logic [TAG_W-1:0] addr_q, addr_d;
  logic             drop_q, drop_d;

  logic             active;
  logic [TAG_W-1:0] wtag;
  logic             cur_hit;
  logic             nxt_hit;

  assign active  = ~rom.rom_ce_n & ~rom.rom_oe_n;
  assign wtag    = rom.rom_addr[ADDR_W-1:1];
  assign cur_hit = cur_q.v & (cur_q.tag == wtag);
  assign nxt_hit = nxt_q.v & (nxt_q.tag == wtag);

  // Byte accesses keep the high byte on [15:8] and steer the addressed byte onto [7:0].
  assign rom.rom_q    = {cur_q.data[15:8],
                         (rom.rom_word | ~rom.rom_addr[0]) ? cur_q.data[7:0] : cur_q.data[15:8]};
  assign rom.rom_busy = active & ~cur_hit;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    drop_d  = drop_q;

    unique case (state_q)
      S_IDLE: begin
        // A flush cycle issues nothing, so a concurrent miss is re-seen against cleared entries.
        if (!rom.flush) begin
          if (active && !cur_hit && !nxt_hit) begin
            state_d = S_DEMAND;
            req_d   = 1'b1;
            addr_d  = wtag;
          end else if (active && !cur_hit && nxt_hit) begin
            cur_d   = nxt_q;
            nxt_d.v = 1'b0;
          end else if (PREFETCH && cur_q.v && !nxt_q.v) begin
            state_d = S_PREFETCH;
            req_d   = 1'b1;
            addr_d  = cur_q.tag + TAG_W'(1);
          end
        end
      end

      S_DEMAND, S_PREFETCH: begin
        if (rom.flush) drop_d = 1'b1;
        if (mem.mem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          drop_d  = 1'b0;
          // Data fetched before (or alongside) a flush may belong to the old ROM image.
          if (!drop_q && !rom.flush) begin
            if (state_q == S_DEMAND) cur_d = '{v: 1'b1, tag: addr_q, data: mem.mem_q};
            else                     nxt_d = '{v: 1'b1, tag: addr_q, data: mem.mem_q};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (rom.flush) begin
      cur_d.v = 1'b0;
      nxt_d.v = 1'b0;
    end
  end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Bench for cart_rom_fetch: SDRAM responder model with an expected-request scoreboard.
module tb_cart_rom_fetch;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned TAG_W  = ADDR_W - 1;

  logic mclk = 1'b0;
  logic rst_n;

  cart_rom_bus_if #(.ADDR_W(ADDR_W)) rb ();
  cart_mem_if     #(.ADDR_W(ADDR_W)) mb ();

  cart_rom_fetch #(.PREFETCH(1'b1), .ADDR_W(ADDR_W)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .rom   (rb),
    .mem   (mb)
  );

  always #5 mclk = ~mclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  bit [TAG_W-1:0] exp_req[$];
  logic [15:0]    sdram [bit [TAG_W-1:0]];
  bit             auto_ack = 1'b1;
  int             ack_lat  = 1;
  int             man_req  = 0;
  int             man_done = 0;
  logic [15:0]    man_data = '0;
  int             ack_cnt  = 0;
  int             last_ack_cyc = 0;

  function automatic logic [15:0] sd_data(input bit [TAG_W-1:0] t);
    if (sdram.exists(t)) return sdram[t];
    return {t[7:0], ~t[7:0]} ^ 16'h0F0F;
  endfunction

  // SDRAM model: checks each new request against the scoreboard, then acks after ack_lat cycles.
  initial begin : sdram_model
    bit seen;
    int cnt;
    bit [TAG_W-1:0] want;
    seen = 1'b0;
    cnt  = 0;
    mb.mem_ack = 1'b0;
    mb.mem_q   = '0;
    forever begin
      @(negedge mclk);
      if (mb.mem_ack) begin
        mb.mem_ack = 1'b0;
        seen = 1'b0;
      end else if (man_req != man_done) begin
        man_done   = man_req;
        mb.mem_ack = 1'b1;
        mb.mem_q   = man_data;
        ack_cnt++;
        last_ack_cyc = cyc;
      end else if (!mb.mem_req || !rst_n) begin
        seen = 1'b0;
      end else if (auto_ack) begin
        if (!seen) begin
          seen = 1'b1;
          cnt  = ack_lat;
          n_vec++;
          if (exp_req.size() == 0) begin
            n_err++;
            $display("FAIL req_order: unexpected request mem_addr=%h, none expected", mb.mem_addr);
          end else begin
            want = exp_req.pop_front();
            if (mb.mem_addr !== want) begin
              n_err++;
              $display("FAIL req_addr: mem_addr=%h expected %h", mb.mem_addr, want);
            end
          end
        end
        if (cnt == 0) begin
          mb.mem_ack = 1'b1;
          mb.mem_q   = sd_data(mb.mem_addr);
          ack_cnt++;
          last_ack_cyc = cyc;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic set_bus(input logic [23:0] a, input bit word, input bit act);
    @(posedge mclk); #1;
    rb.rom_addr = a;
    rb.rom_word = word;
    rb.rom_ce_n = ~act;
    rb.rom_oe_n = ~act;
  endtask

  task automatic wait_busy_low(output bit to);
    to = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (!rb.rom_busy) begin
        to = 1'b0;
        break;
      end
      @(negedge mclk);
    end
  endtask

  task automatic wait_idle(output bit to);
    int quiet;
    quiet = 0;
    to = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge mclk);
      if (mb.mem_req || exp_req.size() != 0) quiet = 0;
      else quiet++;
      if (quiet >= 3) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge mclk); #1;
    rst_n = 1'b0;
    rb.rom_ce_n = 1'b1;
    rb.rom_oe_n = 1'b1;
    rb.rom_addr = '0;
    rb.rom_word = 1'b1;
    rb.flush    = 1'b0;
    exp_req.delete();
    auto_ack = 1'b1;
    ack_lat  = 1;
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: mem_req=%b expected 0", mb.mem_req); end
    n_vec++; if (mb.mem_addr !== 23'h0) begin n_err++; $display("FAIL rst_addr: mem_addr=%h expected 000000", mb.mem_addr); end
    n_vec++; if (rb.rom_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: rom_busy=%b expected 0", rb.rom_busy); end
    n_vec++; if (rb.rom_q !== 16'h0) begin n_err++; $display("FAIL rst_q: rom_q=%h expected 0000", rb.rom_q); end
    rst_n = 1'b1;
  endtask

  task automatic test_demand();
    bit to;
    sdram[23'h000080] = 16'hBEEF;
    ack_lat = 3;
    exp_req.push_back(23'h000080);
    exp_req.push_back(23'h000081);
    set_bus(24'h000100, 1'b1, 1'b1);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b1 || mb.mem_req !== 1'b0) begin
      n_err++; $display("FAIL demand_miss: busy=%b req=%b expected 1/0", rb.rom_busy, mb.mem_req); end
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b1 || mb.mem_addr !== 23'h000080) begin
      n_err++; $display("FAIL demand_req: req=%b addr=%h expected 1/000080", mb.mem_req, mb.mem_addr); end
    wait_busy_low(to);
    n_vec++; if (to) begin n_err++; $display("FAIL demand_timeout: rom_busy stuck=1 expected 0"); end
    n_vec++; if (cyc !== last_ack_cyc + 1) begin
      n_err++; $display("FAIL demand_release: busy low cycle %0d expected %0d", cyc, last_ack_cyc + 1); end
    n_vec++; if (rb.rom_q !== 16'hBEEF) begin n_err++; $display("FAIL demand_q: rom_q=%h expected beef", rb.rom_q); end
  endtask

  task automatic test_byte();
    bit to;
    set_bus(24'h000100, 1'b0, 1'b1);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b0 || rb.rom_q !== 16'hBEEF) begin
      n_err++; $display("FAIL byte_even: busy=%b rom_q=%h expected 0/beef", rb.rom_busy, rb.rom_q); end
    set_bus(24'h000101, 1'b0, 1'b1);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b0 || rb.rom_q !== 16'hBEBE) begin
      n_err++; $display("FAIL byte_odd: busy=%b rom_q=%h expected 0/bebe", rb.rom_busy, rb.rom_q); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL byte_idle: pending=%0d expected 0", exp_req.size()); end
  endtask

  task automatic test_prefetch();
    bit to;
    apply_reset();
    sdram[23'h000080] = 16'h1111;
    sdram[23'h000081] = 16'h2222;
    sdram[23'h000082] = 16'h3333;
    ack_lat = 2;
    exp_req.push_back(23'h000080);
    exp_req.push_back(23'h000081);
    set_bus(24'h000100, 1'b1, 1'b1);
    @(negedge mclk);
    wait_busy_low(to);
    n_vec++; if (to || rb.rom_q !== 16'h1111) begin
      n_err++; $display("FAIL pf_first: timeout=%b rom_q=%h expected 0/1111", to, rb.rom_q); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL pf_issue: pending=%0d expected 0", exp_req.size()); end
    exp_req.push_back(23'h000082);
    set_bus(24'h000102, 1'b1, 1'b1);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b1) begin n_err++; $display("FAIL pf_promote_busy: rom_busy=%b expected 1", rb.rom_busy); end
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b0 || rb.rom_q !== 16'h2222) begin
      n_err++; $display("FAIL pf_promote_q: busy=%b rom_q=%h expected 0/2222", rb.rom_busy, rb.rom_q); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL pf_next: pending=%0d expected 0", exp_req.size()); end
  endtask

  task automatic test_wrap();
    bit to;
    apply_reset();
    exp_req.push_back(23'h7FFFFF);
    exp_req.push_back(23'h000000);
    set_bus(24'hFFFFFE, 1'b1, 1'b1);
    @(negedge mclk);
    wait_busy_low(to);
    n_vec++; if (to || rb.rom_q !== sd_data(23'h7FFFFF)) begin
      n_err++; $display("FAIL wrap_top: timeout=%b rom_q=%h expected 0/%h", to, rb.rom_q, sd_data(23'h7FFFFF)); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL wrap_pf: pending=%0d expected 0", exp_req.size()); end
    exp_req.push_back(23'h000001);
    set_bus(24'h000000, 1'b1, 1'b1);
    @(negedge mclk);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b0 || rb.rom_q !== sd_data(23'h000000)) begin
      n_err++; $display("FAIL wrap_zero: busy=%b rom_q=%h expected 0/%h", rb.rom_busy, rb.rom_q, sd_data(23'h000000)); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL wrap_idle: pending=%0d expected 0", exp_req.size()); end
  endtask

  task automatic test_addr_change();
    bit to;
    int acks0;
    apply_reset();
    ack_lat = 4;
    exp_req.push_back(23'h000100);
    set_bus(24'h000200, 1'b1, 1'b1);
    @(negedge mclk);
    @(negedge mclk);
    acks0 = ack_cnt;
    exp_req.push_back(23'h000200);
    exp_req.push_back(23'h000201);
    set_bus(24'h000400, 1'b1, 1'b1);
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b1 || mb.mem_addr !== 23'h000100) begin
      n_err++; $display("FAIL chg_hold: req=%b addr=%h expected 1/000100", mb.mem_req, mb.mem_addr); end
    wait_busy_low(to);
    n_vec++; if (to || ack_cnt - acks0 !== 2 || cyc !== last_ack_cyc + 1) begin
      n_err++; $display("FAIL chg_busy: timeout=%b acks=%0d release=%0d expected 0/2/%0d",
                        to, ack_cnt - acks0, cyc, last_ack_cyc + 1); end
    n_vec++; if (rb.rom_q !== sd_data(23'h000200)) begin
      n_err++; $display("FAIL chg_q: rom_q=%h expected %h", rb.rom_q, sd_data(23'h000200)); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL chg_idle: pending=%0d expected 0", exp_req.size()); end
  endtask

  task automatic test_flush();
    bit to;
    apply_reset();
    auto_ack = 1'b0;
    set_bus(24'h000100, 1'b1, 1'b1);
    @(negedge mclk);
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b1 || mb.mem_addr !== 23'h000080) begin
      n_err++; $display("FAIL fl_req: req=%b addr=%h expected 1/000080", mb.mem_req, mb.mem_addr); end
    @(posedge mclk); #1;
    rb.flush = 1'b1;
    man_data = 16'hCAFE;
    man_req++;
    @(posedge mclk); #1;
    rb.flush = 1'b0;
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b1 || mb.mem_req !== 1'b0) begin
      n_err++; $display("FAIL fl_ack_drop: busy=%b req=%b expected 1/0", rb.rom_busy, mb.mem_req); end
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b1 || mb.mem_addr !== 23'h000080) begin
      n_err++; $display("FAIL fl_remiss: req=%b addr=%h expected 1/000080", mb.mem_req, mb.mem_addr); end
    @(posedge mclk); #1;
    exp_req.push_back(23'h000081);
    ack_lat  = 3;
    man_data = 16'hD00D;
    man_req++;
    auto_ack = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b0 || rb.rom_q !== 16'hD00D) begin
      n_err++; $display("FAIL fl_refill: busy=%b rom_q=%h expected 0/d00d", rb.rom_busy, rb.rom_q); end
    // Flush while the prefetch is in flight: its fill must be dropped.
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge mclk);
      if (mb.mem_req) begin to = 1'b0; break; end
    end
    exp_req.push_back(23'h000080);
    exp_req.push_back(23'h000081);
    @(posedge mclk); #1;
    rb.flush = 1'b1;
    @(posedge mclk); #1;
    rb.flush = 1'b0;
    @(negedge mclk);
    n_vec++; if (to || rb.rom_busy !== 1'b1) begin
      n_err++; $display("FAIL fl_inflight: timeout=%b busy=%b expected 0/1", to, rb.rom_busy); end
    wait_busy_low(to);
    n_vec++; if (to || rb.rom_q !== sd_data(23'h000080)) begin
      n_err++; $display("FAIL fl_recover: timeout=%b rom_q=%h expected 0/%h", to, rb.rom_q, sd_data(23'h000080)); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL fl_idle: pending=%0d expected 0", exp_req.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    apply_reset();
    auto_ack = 1'b0;
    set_bus(24'h000300, 1'b1, 1'b1);
    @(negedge mclk);
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b1 || mb.mem_addr !== 23'h000180) begin
      n_err++; $display("FAIL rm_req: req=%b addr=%h expected 1/000180", mb.mem_req, mb.mem_addr); end
    #2;
    rst_n = 1'b0;
    rb.rom_ce_n = 1'b1;
    rb.rom_oe_n = 1'b1;
    #1;
    n_vec++; if (mb.mem_req !== 1'b0) begin n_err++; $display("FAIL rm_async: mem_req=%b expected 0", mb.mem_req); end
    @(negedge mclk);
    rst_n = 1'b1;
    @(posedge mclk); #1;
    man_data = 16'h5555;
    man_req++;
    @(negedge mclk);
    @(negedge mclk);
    n_vec++; if (mb.mem_req !== 1'b0 || rb.rom_busy !== 1'b0 || rb.rom_q !== 16'h0) begin
      n_err++; $display("FAIL rm_stray_ack: req=%b busy=%b rom_q=%h expected 0/0/0000",
                        mb.mem_req, rb.rom_busy, rb.rom_q); end
    exp_req.push_back(23'h000180);
    exp_req.push_back(23'h000181);
    auto_ack = 1'b1;
    set_bus(24'h000300, 1'b1, 1'b1);
    @(negedge mclk);
    n_vec++; if (rb.rom_busy !== 1'b1) begin n_err++; $display("FAIL rm_miss: rom_busy=%b expected 1", rb.rom_busy); end
    wait_busy_low(to);
    n_vec++; if (to || rb.rom_q !== sd_data(23'h000180)) begin
      n_err++; $display("FAIL rm_fill: timeout=%b rom_q=%h expected 0/%h", to, rb.rom_q, sd_data(23'h000180)); end
    wait_idle(to);
    n_vec++; if (to) begin n_err++; $display("FAIL rm_idle: pending=%0d expected 0", exp_req.size()); end
  endtask

  initial begin
    rst_n       = 1'b0;
    rb.rom_addr = '0;
    rb.rom_ce_n = 1'b1;
    rb.rom_oe_n = 1'b1;
    rb.rom_word = 1'b1;
    rb.flush    = 1'b0;
    test_reset();
    test_demand();
    test_byte();
    test_prefetch();
    test_wrap();
    test_addr_change();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
